// File: rtl/mem_pkg.sv
// mem_pkg: shared constants and types for the multi-port byte memory.
//   - default geometry (bytes in array, bytes per access word)
//   - byte address map of the protocol state kept in the array
//   - controller state enum
package mem_pkg;

   localparam int MEM_DEPTH_DEF  = 2048;
   localparam int WORD_BYTES_DEF = 2;

   // Byte address map used by the protocol FSMs
   localparam logic [15:0] ADDR_FLAGS                 = 16'h0000;
   localparam logic [15:0] ADDR_KNOWN_SINKS           = 16'h0008;
   localparam logic [15:0] ADDR_WORST_HOPS            = 16'h0028;
   localparam logic [15:0] ADDR_NEIGHBOR_ID           = 16'h0048;
   localparam logic [15:0] ADDR_CLUSTER_ID            = 16'h00C8;
   localparam logic [15:0] ADDR_BATTERY_STAT          = 16'h0148;
   localparam logic [15:0] ADDR_QVALUE                = 16'h01C8;
   localparam logic [15:0] ADDR_SINK_IDS              = 16'h0248;
   localparam logic [15:0] ADDR_HOP_MULT              = 16'h0648;
   localparam logic [15:0] ADDR_BETTER_NEIGHBORS      = 16'h0668;
   localparam logic [15:0] ADDR_KNOWN_SINK_COUNT      = 16'h0688;
   localparam logic [15:0] ADDR_NEIGHBOR_COUNT        = 16'h068A;
   localparam logic [15:0] ADDR_BETTER_NEIGHBOR_COUNT = 16'h068C;
   localparam logic [15:0] ADDR_SINK_ID_COUNT         = 16'h068E;
   localparam logic [15:0] ADDR_RNG_SEED              = 16'h0798;

   typedef enum logic {
      CLEAR = 1'b0,
      SERVE = 1'b1
   } state_e;

endpackage

// File: rtl/mem_mp_rr_arbiter.sv
// rr_arbiter: round-robin pick among N_CH requesters.
//   req       in   one bit per requester
//   ptr       in   last granted index; search starts at ptr+1 mod N_CH
//   grant     out  one-hot grant (all zero when no request)
//   grant_idx out  index of granted requester
//   grant_vld out  some requester was granted
module rr_arbiter #(
   parameter int N_CH = 2,
   parameter int PW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic [N_CH-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [N_CH-1:0] grant,
   output logic [PW-1:0]   grant_idx,
   output logic            grant_vld
);

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_vld = 1'b0;
      // k runs 1..N_CH so the previous winner is searched last
      for (int k = 1; k <= N_CH; k++) begin
         if (!grant_vld && req[(int'(ptr) + k) % N_CH]) begin
            grant_vld = 1'b1;
            grant_idx = PW'((int'(ptr) + k) % N_CH);
         end
      end
      grant[grant_idx] = grant_vld;
   end

endmodule

// File: rtl/mem_mp.sv
// mem_mp: byte-addressed, big-endian word store shared by N_CH requesters.
//   clock, reset          system clock, synchronous active-high reset
//   req_valid/ready/wr    per-channel handshake and direction
//   req_addr/wdata/be     per-channel byte address, write word, byte enables
//   rsp_valid/rsp_rdata   per-channel one-cycle read pulse and held read data
//   busy                  post-reset clear sequence running
// One access per cycle, round-robin among channels. INIT_FILE names an image
// for the memory-init back-end flow; the RTL array itself is not preloaded.
module mem_mp
   import mem_pkg::*;
#(
   parameter int    MEM_DEPTH      = MEM_DEPTH_DEF,
   parameter int    ADDR_W         = 16,
   parameter int    WORD_BYTES     = WORD_BYTES_DEF,
   parameter int    N_CH           = 2,
   parameter int    CLEAR_ON_RESET = 1,
   parameter string INIT_FILE      = "mem.txt"
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [N_CH-1:0]              req_valid,
   output logic [N_CH-1:0]              req_ready,
   input  logic [N_CH-1:0]              req_wr,
   input  logic [N_CH*ADDR_W-1:0]       req_addr,
   input  logic [N_CH*8*WORD_BYTES-1:0] req_wdata,
   input  logic [N_CH*WORD_BYTES-1:0]   req_be,
   output logic [N_CH-1:0]              rsp_valid,
   output logic [N_CH*8*WORD_BYTES-1:0] rsp_rdata,
   output logic                         busy
);

   localparam int WORD_W  = 8 * WORD_BYTES;
   localparam int AW      = $clog2(MEM_DEPTH);
   localparam int PW      = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int N_WORDS = MEM_DEPTH / WORD_BYTES;
   localparam int CW      = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

   state_e                   state_q, state_d;
   logic [PW-1:0]            ptr_q, ptr_d;
   logic [CW-1:0]            clr_cnt_q, clr_cnt_d;
   logic [N_CH-1:0]          rsp_valid_q, rsp_valid_d;
   logic [N_CH*WORD_W-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic [7:0]               mem_q [MEM_DEPTH];

   logic [N_CH-1:0]          grant;
   logic [PW-1:0]            g_idx;
   logic                     grant_vld;

   logic                     sel_wr;
   logic [ADDR_W-1:0]        sel_addr;
   logic [WORD_W-1:0]        sel_wdata;
   logic [WORD_BYTES-1:0]    sel_be;

   // one byte lane per word byte, k=0 is the MSB / lowest address
   logic [AW-1:0]            b_addr  [WORD_BYTES];
   logic [7:0]               b_wdata [WORD_BYTES];
   logic [WORD_BYTES-1:0]    b_we;
   logic [WORD_W-1:0]        rd_word;

   if (INIT_FILE != "") begin : g_init_image
   end

   rr_arbiter #(.N_CH(N_CH), .PW(PW)) u_arb (
      .req       (req_valid & {N_CH{state_q == SERVE}}),
      .ptr       (ptr_q),
      .grant     (grant),
      .grant_idx (g_idx),
      .grant_vld (grant_vld)
   );

   assign sel_wr    = req_wr[g_idx];
   assign sel_addr  = req_addr[g_idx*ADDR_W +: ADDR_W];
   assign sel_wdata = req_wdata[g_idx*WORD_W +: WORD_W];
   assign sel_be    = req_be[g_idx*WORD_BYTES +: WORD_BYTES];

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      clr_cnt_d   = clr_cnt_q;
      rsp_valid_d = '0;
      rsp_rdata_d = rsp_rdata_q;
      b_we        = '0;
      rd_word     = '0;
      for (int k = 0; k < WORD_BYTES; k++) begin
         b_addr[k]  = '0;
         b_wdata[k] = '0;
      end

      case (state_q)
         CLEAR: begin
            for (int k = 0; k < WORD_BYTES; k++) begin
               b_addr[k] = AW'(int'(clr_cnt_q) * WORD_BYTES + k);
            end
            b_we      = '1;
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == CW'(N_WORDS - 1)) begin
               state_d   = SERVE;
               clr_cnt_d = '0;
            end
         end
         default: begin
            // upper address bits drop out here, which also wraps the array end
            for (int k = 0; k < WORD_BYTES; k++) begin
               b_addr[k]  = AW'(sel_addr + ADDR_W'(k));
               b_wdata[k] = sel_wdata[(WORD_BYTES-1-k)*8 +: 8];
               rd_word[(WORD_BYTES-1-k)*8 +: 8] = mem_q[b_addr[k]];
            end
            if (grant_vld) begin
               ptr_d = g_idx;
               if (sel_wr) begin
                  for (int k = 0; k < WORD_BYTES; k++) begin
                     b_we[k] = sel_be[WORD_BYTES-1-k];
                  end
               end else begin
                  rsp_valid_d[g_idx]                      = 1'b1;
                  rsp_rdata_d[g_idx*WORD_W +: WORD_W]     = rd_word;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= (CLEAR_ON_RESET != 0) ? CLEAR : SERVE;
         ptr_q       <= PW'(N_CH - 1);
         clr_cnt_q   <= '0;
         rsp_valid_q <= '0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         clr_cnt_q   <= clr_cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   // array contents survive reset; only the clear sequence zeroes them
   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int k = 0; k < WORD_BYTES; k++) begin
            if (b_we[k]) mem_q[b_addr[k]] <= b_wdata[k];
         end
      end
   end

   assign req_ready = grant;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign busy      = (state_q == CLEAR);

endmodule

// File: tb/tb_mem_mp.sv
module tb_mem_mp;
   localparam int DEPTH = 2048;
   localparam int AWT   = 16;
   localparam int WB    = 2;
   localparam int NC    = 2;
   localparam int WW    = 8 * WB;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   logic [NC-1:0]     req_valid = '0, req_wr = '0, req_ready, rsp_valid;
   logic [NC*AWT-1:0] req_addr  = '0;
   logic [NC*WW-1:0]  req_wdata = '0, rsp_rdata;
   logic [NC*WB-1:0]  req_be    = '0;
   logic              busy;

   int errors = 0;
   int checks = 0;

   mem_mp #(.MEM_DEPTH(DEPTH), .ADDR_W(AWT), .WORD_BYTES(WB), .N_CH(NC),
            .CLEAR_ON_RESET(1), .INIT_FILE("")) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [7:0]    m_mem [DEPTH];
   bit            m_init = 0;
   bit            m_busy;
   int            m_left, m_ptr;
   logic [NC-1:0] m_rv;
   logic [WW-1:0] m_rd [NC];
   int            mg, ma;

   function automatic int pick(input logic [NC-1:0] v, input int p);
      int c;
      for (int k = 1; k <= NC; k++) begin
         c = (p + k) % NC;
         if (v[c]) return c;
      end
      return -1;
   endfunction

   function automatic logic [WW-1:0] word_at(input int a);
      logic [WW-1:0] w;
      w = '0;
      for (int k = 0; k < WB; k++) w = (w << 8) | WW'(m_mem[(a + k) % DEPTH]);
      return w;
   endfunction

   always @(posedge clock) begin
      if (reset) begin
         m_init = 1;
         m_busy = 1;
         m_left = DEPTH / WB;
         m_ptr  = NC - 1;
         m_rv   = '0;
         for (int c = 0; c < NC; c++) m_rd[c] = '0;
         // after the clear the whole array is zero; no read can land before that
         for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
      end else if (m_busy) begin
         m_rv = '0;
         m_left--;
         if (m_left == 0) m_busy = 0;
      end else begin
         m_rv = '0;
         mg = pick(req_valid, m_ptr);
         if (mg >= 0) begin
            m_ptr = mg;
            ma = int'(req_addr[mg*AWT +: AWT]) % DEPTH;
            if (req_wr[mg]) begin
               for (int k = 0; k < WB; k++)
                  if (req_be[mg*WB + WB-1-k])
                     m_mem[(ma + k) % DEPTH] = req_wdata[mg*WW + (WB-1-k)*8 +: 8];
            end else begin
               m_rv[mg] = 1'b1;
               m_rd[mg] = word_at(ma);
            end
         end
      end
   end

   // per-cycle compare against the model
   logic [NC-1:0] exp_rdy;
   int            eg;
   always @(negedge clock) begin
      if (m_init) begin
         exp_rdy = '0;
         if (!m_busy) begin
            eg = pick(req_valid, m_ptr);
            if (eg >= 0) exp_rdy[eg] = 1'b1;
         end
         chk("busy", 32'(busy), 32'(m_busy));
         chk("req_ready", 32'(req_ready), 32'(exp_rdy));
         chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
         for (int c = 0; c < NC; c++) chk("rsp_rdata", 32'(rsp_rdata[c*WW +: WW]), 32'(m_rd[c]));
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic set_ch(input int c, input bit v, input bit wr, input int addr,
                         input logic [WW-1:0] wd, input logic [WB-1:0] be);
      req_valid[c]            = v;
      req_wr[c]               = wr;
      req_addr[c*AWT +: AWT]  = AWT'(addr);
      req_wdata[c*WW +: WW]   = wd;
      req_be[c*WB +: WB]      = be;
   endtask

   task automatic xact(input int c, input bit wr, input int addr,
                       input logic [WW-1:0] wd, input logic [WB-1:0] be);
      bit ok;
      ok = 0;
      set_ch(c, 1, wr, addr, wd, be);
      for (int i = 0; i < 3000; i++) begin
         @(negedge clock);
         if (req_ready[c]) begin
            ok = 1;
            break;
         end
      end
      if (!ok) chk("grant_timeout", 0, 1);
      step();
      req_valid[c] = 1'b0;
   endtask

   task automatic rd_chk(input string nm, input int c, input int addr, input logic [WW-1:0] exp);
      xact(c, 0, addr, '0, '0);
      @(negedge clock);
      chk({nm, "_vld"}, 32'(rsp_valid[c]), 1);
      chk(nm, 32'(rsp_rdata[c*WW +: WW]), 32'(exp));
      step();
   endtask

   task automatic count_busy(output int n);
      n = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clock);
         if (!busy) break;
         n++;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n, c0, c1, nz;
      logic [7:0] seq;
      logic [NC-1:0] gl;

      repeat (3) step();
      // reset state right after reset edges
      chk("rst_busy", 32'(busy), 1);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_rdata", 32'(rsp_rdata), 0);

      // ch1 waits with a read of 0x5 throughout the clear
      set_ch(1, 1, 0, 'h5, '0, '0);
      reset = 1'b0;
      count_busy(n);
      chk("clear_cycles", 32'(n), 1024);
      chk("first_grant_ch1", 32'(req_ready), 32'b10);
      step();
      req_valid[1] = 1'b0;
      @(negedge clock);
      chk("rd_5_vld", 32'(rsp_valid[1]), 1);
      chk("rd_5", 32'(rsp_rdata[WW +: WW]), 0);
      step();

      // word write/read, byte-offset read
      xact(0, 1, 'h68A, 16'h1234, 2'b11);
      rd_chk("rd_68A", 0, 'h68A, 16'h1234);
      rd_chk("rd_68B", 0, 'h68B, 16'h3400);

      // partial byte-enable merge
      xact(0, 1, 'h100, 16'h1234, 2'b11);
      xact(0, 1, 'h100, 16'hAABB, 2'b10);
      rd_chk("rd_merge", 1, 'h100, 16'hAA34);

      // both channels hold reads: grants alternate starting at ch0
      set_ch(0, 1, 0, 'h68A, '0, '0);
      set_ch(1, 1, 0, 'h100, '0, '0);
      seq = '0; c0 = 0; c1 = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         seq = {seq[5:0], req_ready};
         if (i > 0) begin
            c0 += int'(rsp_valid[0]);
            c1 += int'(rsp_valid[1]);
         end
         @(posedge clock);
         if (i == 3) begin
            #1;
            req_valid = '0;
         end
      end
      @(negedge clock);
      c0 += int'(rsp_valid[0]);
      c1 += int'(rsp_valid[1]);
      chk("rr_sequence", 32'(seq), 32'b01_10_01_10);
      chk("rr_rsp_ch0", 32'(c0), 2);
      chk("rr_rsp_ch1", 32'(c1), 2);
      step();

      // wrap at the end of the array
      xact(0, 1, 'h7FF, 16'hCAFE, 2'b11);
      rd_chk("rd_7FF", 0, 'h7FF, 16'hCAFE);
      rd_chk("rd_000", 1, 'h000, 16'hFE00);
      rd_chk("rd_7FE", 0, 'h7FE, 16'h00CA);

      // randomized traffic, fields held until granted
      gl = '0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int c = 0; c < NC; c++) begin
            if (!req_valid[c] || gl[c]) begin
               if ($urandom_range(0, 3) == 0)
                  set_ch(c, 0, 0, 0, '0, '0);
               else
                  set_ch(c, 1, 1'($urandom_range(0, 1)),
                         $urandom_range(0, 1) ? int'($urandom_range(0, 65535))
                                              : int'('h7F0 + $urandom_range(0, 31)),
                         WW'($urandom), WB'($urandom_range(0, 3)));
            end
         end
         @(negedge clock);
         gl = req_ready;
         step();
      end
      req_valid = '0;
      step();

      // reset in the middle of a clear restarts it from zero
      reset = 1'b1;
      step();
      reset = 1'b0;
      repeat (500) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      count_busy(n);
      chk("clear_restart_cycles", 32'(n), 1024);
      step();
      nz = 0;
      for (int i = 0; i < DEPTH / WB; i++) begin
         xact(0, 0, i * WB, '0, '0);
         @(negedge clock);
         if (rsp_rdata[WW-1:0] !== '0 || rsp_valid[0] !== 1'b1) nz++;
         step();
      end
      chk("array_zero", 32'(nz), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
